// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings (funct3[1:0])
//   - response fault cause codes
//   - FSM state encoding (also exported on the debug port)
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   i_off      byte offset of the access inside a bus word
//   i_size     size encoding (byte/half/word/double)
//   i_wdata    right-justified store data
//   i_stage    two-word load staging register (beat 1 low, beat 2 high)
//   i_unsigned zero-extend instead of sign-extend
//   o_be1/2    byte enables for beat 1 / beat 2
//   o_wdata1/2 lane-shifted store data for beat 1 / beat 2
//   o_rdata    extracted and extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int B    = XLEN / 8,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [OFFW-1:0]   i_off,
    input  logic [1:0]        i_size,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [2*XLEN-1:0] i_stage,
    input  logic              i_unsigned,
    output logic [B-1:0]      o_be1,
    output logic [B-1:0]      o_be2,
    output logic [XLEN-1:0]   o_wdata1,
    output logic [XLEN-1:0]   o_wdata2,
    output logic [XLEN-1:0]   o_rdata
);

    logic [3:0]        w_nbytes;
    logic [2*B-1:0]    w_base;
    logic [2*B-1:0]    w_mask;
    logic [OFFW+3:0]   w_sh1;
    logic [OFFW+3:0]   w_sh2;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_keep;
    logic              w_sign;

    always_comb begin
        w_nbytes = 4'd1 << i_size;
        // Mask is built 2B wide so the lanes spilling past the bus word
        // land in the upper half and become the second-beat enables.
        w_base   = ((2*B)'(1) << w_nbytes) - (2*B)'(1);
        w_mask   = w_base << i_off;
        o_be1    = w_mask[B-1:0];
        o_be2    = w_mask[2*B-1:B];

        w_sh1    = {1'b0, i_off, 3'b000};
        w_sh2    = (OFFW+4)'(XLEN) - w_sh1;
        o_wdata1 = i_wdata << w_sh1;
        o_wdata2 = i_wdata >> w_sh2;

        // Staging holds beat 1 in the low word and beat 2 in the high word,
        // so a single right shift by the offset lines up every access.
        w_raw    = XLEN'(i_stage >> w_sh1);

        w_keep   = '1;
        w_sign   = 1'b0;
        case (i_size)
            SZ_B: begin
                w_keep = XLEN'(8'hFF);
                w_sign = w_raw[7];
            end
            SZ_H: begin
                w_keep = XLEN'(16'hFFFF);
                w_sign = w_raw[15];
            end
            SZ_W: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_sign = w_raw[XLEN == 32 ? 0 : 31];
            end
            default: begin
                w_keep = '1;
                w_sign = 1'b0;
            end
        endcase
        o_rdata = (w_raw & w_keep) | (~w_keep & {XLEN{w_sign & ~i_unsigned}});
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store engine between the core and the memory bus.
//   clk, rst          clock, synchronous active-high reset
//   req_*             one request at a time from the core
//   rsp_*             one-cycle response pulse (data, fault, cause)
//   rd_en_o/wr_en_o   registered bus strobes, held until ack_i
//   byte_enable_o     lane enables; addr_o is always bus-word aligned
//   data_o/data_i     lane-shifted store data / bus read data
//   ack_i             bus completion for the current beat
//   dbg_state_o       current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; ready is high only in IDLE and the request
// fields need only be valid in that cycle. A bus beat completes on the edge
// where ack_i is high while a strobe is asserted; the strobes and fields are
// held stable until then and drop on that edge.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int TIMEOUT_CYCLES   = 256,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    localparam int B               = XLEN / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [XLEN-1:0]  req_addr_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    output logic             rsp_valid_o,
    output logic [XLEN-1:0]  rsp_rdata_o,
    output logic             rsp_fault_o,
    output logic [1:0]       rsp_cause_o,
    output logic             rd_en_o,
    output logic             wr_en_o,
    output logic [B-1:0]     byte_enable_o,
    output logic [XLEN-1:0]  addr_o,
    output logic [XLEN-1:0]  data_o,
    input  logic [XLEN-1:0]  data_i,
    input  logic             ack_i,
    output lsu_state_t       dbg_state_o
);

    localparam int OFFW    = $clog2(B);
    localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    lsu_state_t        r_state, w_state_next;
    logic              r_write, r_unsigned, r_cross, r_fault;
    logic [1:0]        r_size, r_cause;
    logic [XLEN-1:0]   r_addr, r_wdata;
    logic              r_rd_en, r_wr_en;
    logic [B-1:0]      r_be;
    logic [XLEN-1:0]   r_bus_addr, r_bus_data;
    logic [2*XLEN-1:0] r_stage;
    logic [CW-1:0]     r_wdog;

    logic [OFFW-1:0]   w_in_off, w_off;
    logic [1:0]        w_in_size, w_size;
    logic [4:0]        w_in_end;
    logic              w_in_cross, w_in_illegal, w_in_misalign;
    logic [XLEN-1:0]   w_in_aligned, w_aligned, w_wdata;
    logic              w_live, w_timeout;
    logic [B-1:0]      w_be1, w_be2;
    logic [XLEN-1:0]   w_wdata1, w_wdata2, w_rdata;

    // Request decode straight from the inputs; only used on acceptance.
    assign w_in_off      = req_addr_i[OFFW-1:0];
    assign w_in_size     = req_funct3_i[1:0];
    assign w_in_end      = 5'(w_in_off) + (5'd1 << w_in_size);
    assign w_in_cross    = (w_in_end > 5'(B));
    assign w_in_illegal  = ((w_in_size == SZ_D) && (XLEN == 32)) ||
                           (req_write_i && req_funct3_i[2]);
    assign w_in_misalign = w_in_cross && !SPLIT_MISALIGNED;
    assign w_in_aligned  = {req_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign w_aligned     = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    // In IDLE the aligner sees the incoming request so beat 1 can be
    // launched on the acceptance edge; afterwards it sees the held request.
    assign w_off   = (r_state == ST_IDLE) ? w_in_off    : r_addr[OFFW-1:0];
    assign w_size  = (r_state == ST_IDLE) ? w_in_size   : r_size;
    assign w_wdata = (r_state == ST_IDLE) ? req_wdata_i : r_wdata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_off      (w_off),
        .i_size     (w_size),
        .i_wdata    (w_wdata),
        .i_stage    (r_stage),
        .i_unsigned (r_unsigned),
        .o_be1      (w_be1),
        .o_be2      (w_be2),
        .o_wdata1   (w_wdata1),
        .o_wdata2   (w_wdata2),
        .o_rdata    (w_rdata)
    );

    // A beat is live while its strobe is up. The first BEAT2 cycle has no
    // strobe (beat 1 just dropped), which is where beat 2 gets launched.
    assign w_live    = r_rd_en | r_wr_en;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_live && !ack_i &&
                       (r_wdog == CW'(TO_LAST));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (w_in_illegal || w_in_misalign) w_state_next = ST_RESP;
                    else                               w_state_next = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                if (w_live && ack_i)     w_state_next = r_cross ? ST_BEAT2 : ST_RESP;
                else if (w_timeout)      w_state_next = ST_RESP;
            end
            ST_BEAT2: begin
                if (w_live && (ack_i || w_timeout)) w_state_next = ST_RESP;
            end
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_cross    <= 1'b0;
            r_fault    <= 1'b0;
            r_size     <= SZ_B;
            r_cause    <= CAUSE_NONE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_be       <= '0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_stage    <= '0;
            r_wdog     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_write    <= req_write_i;
                        r_unsigned <= req_funct3_i[2];
                        r_size     <= w_in_size;
                        r_addr     <= req_addr_i;
                        r_wdata    <= req_wdata_i;
                        r_cross    <= w_in_cross;
                        r_stage    <= '0;
                        r_wdog     <= '0;
                        if (w_in_illegal) begin
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_ILLEGAL;
                        end else if (w_in_misalign) begin
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_fault    <= 1'b0;
                            r_cause    <= CAUSE_NONE;
                            r_rd_en    <= !req_write_i;
                            r_wr_en    <= req_write_i;
                            r_be       <= w_be1;
                            r_bus_addr <= w_in_aligned;
                            r_bus_data <= req_write_i ? w_wdata1 : '0;
                        end
                    end
                end
                ST_BEAT1, ST_BEAT2: begin
                    if (!w_live) begin
                        r_rd_en    <= !r_write;
                        r_wr_en    <= r_write;
                        r_be       <= w_be2;
                        r_bus_addr <= w_aligned + XLEN'(B);
                        r_bus_data <= r_write ? w_wdata2 : '0;
                        r_wdog     <= '0;
                    end else if (ack_i) begin
                        for (int i = 0; i < B; i++) begin
                            if (r_be[i]) begin
                                if (r_state == ST_BEAT1) r_stage[8*i +: 8]        <= data_i[8*i +: 8];
                                else                     r_stage[XLEN + 8*i +: 8] <= data_i[8*i +: 8];
                            end
                        end
                        r_rd_en    <= 1'b0;
                        r_wr_en    <= 1'b0;
                        r_be       <= '0;
                        r_bus_addr <= '0;
                        r_bus_data <= '0;
                    end else if (w_timeout) begin
                        r_rd_en    <= 1'b0;
                        r_wr_en    <= 1'b0;
                        r_be       <= '0;
                        r_bus_addr <= '0;
                        r_bus_data <= '0;
                        r_fault    <= 1'b1;
                        r_cause    <= CAUSE_TIMEOUT;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o   = (r_state == ST_IDLE);
    assign rsp_valid_o   = (r_state == ST_RESP);
    assign rsp_fault_o   = rsp_valid_o & r_fault;
    assign rsp_cause_o   = rsp_valid_o ? r_cause : CAUSE_NONE;
    assign rsp_rdata_o   = (rsp_valid_o && !r_fault && !r_write) ? w_rdata : '0;
    assign rd_en_o       = r_rd_en;
    assign wr_en_o       = r_wr_en;
    assign byte_enable_o = r_be;
    assign addr_o        = r_bus_addr;
    assign data_o        = r_bus_data;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    int          sel;
    logic        req_valid, req_write, bus_ack;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata, bus_rdata;

    // Instance A: XLEN 32, split, timeout 4
    logic        a_ready, a_rsp_valid, a_fault, a_rd, a_wr;
    logic [1:0]  a_cause;
    logic [31:0] a_rdata, a_addr, a_data;
    logic [3:0]  a_be;
    lsu_state_t  a_state;
    // Instance B: XLEN 32, misaligned faults
    logic        b_ready, b_rsp_valid, b_fault, b_rd, b_wr;
    logic [1:0]  b_cause;
    logic [31:0] b_rdata, b_addr, b_data;
    logic [3:0]  b_be;
    lsu_state_t  b_state;
    // Instance C: XLEN 64, split
    logic        c_ready, c_rsp_valid, c_fault, c_rd, c_wr;
    logic [1:0]  c_cause;
    logic [63:0] c_rdata, c_addr, c_data;
    logic [7:0]  c_be;
    lsu_state_t  c_state;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4), .SPLIT_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid && sel == 0), .req_ready_o(a_ready),
        .req_write_i(req_write), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr[31:0]), .req_wdata_i(req_wdata[31:0]),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .rsp_fault_o(a_fault), .rsp_cause_o(a_cause),
        .rd_en_o(a_rd), .wr_en_o(a_wr), .byte_enable_o(a_be), .addr_o(a_addr), .data_o(a_data),
        .data_i(bus_rdata[31:0]), .ack_i(bus_ack && sel == 0), .dbg_state_o(a_state));

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(256), .SPLIT_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid && sel == 1), .req_ready_o(b_ready),
        .req_write_i(req_write), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr[31:0]), .req_wdata_i(req_wdata[31:0]),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .rsp_fault_o(b_fault), .rsp_cause_o(b_cause),
        .rd_en_o(b_rd), .wr_en_o(b_wr), .byte_enable_o(b_be), .addr_o(b_addr), .data_o(b_data),
        .data_i(bus_rdata[31:0]), .ack_i(bus_ack && sel == 1), .dbg_state_o(b_state));

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(256), .SPLIT_MISALIGNED(1'b1)) u_c (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid && sel == 2), .req_ready_o(c_ready),
        .req_write_i(req_write), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(c_rsp_valid), .rsp_rdata_o(c_rdata), .rsp_fault_o(c_fault), .rsp_cause_o(c_cause),
        .rd_en_o(c_rd), .wr_en_o(c_wr), .byte_enable_o(c_be), .addr_o(c_addr), .data_o(c_data),
        .data_i(bus_rdata), .ack_i(bus_ack && sel == 2), .dbg_state_o(c_state));

    // Selected-instance view used by all checks.
    logic        m_ready, m_rsp_valid, m_fault, m_rd, m_wr;
    logic [1:0]  m_cause, m_state;
    logic [63:0] m_rdata, m_addr, m_data;
    logic [7:0]  m_be;

    always_comb begin
        m_ready = a_ready; m_rsp_valid = a_rsp_valid; m_fault = a_fault; m_rd = a_rd; m_wr = a_wr;
        m_cause = a_cause; m_state = a_state; m_rdata = {32'd0, a_rdata}; m_addr = {32'd0, a_addr};
        m_data = {32'd0, a_data}; m_be = {4'd0, a_be};
        if (sel == 1) begin
            m_ready = b_ready; m_rsp_valid = b_rsp_valid; m_fault = b_fault; m_rd = b_rd; m_wr = b_wr;
            m_cause = b_cause; m_state = b_state; m_rdata = {32'd0, b_rdata}; m_addr = {32'd0, b_addr};
            m_data = {32'd0, b_data}; m_be = {4'd0, b_be};
        end else if (sel == 2) begin
            m_ready = c_ready; m_rsp_valid = c_rsp_valid; m_fault = c_fault; m_rd = c_rd; m_wr = c_wr;
            m_cause = c_cause; m_state = c_state; m_rdata = c_rdata; m_addr = c_addr;
            m_data = c_data; m_be = c_be;
        end
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with the selected unit idle; returns at the
    // negedge of cycle 1 (the cycle after the acceptance edge).
    task automatic issue(input int inst, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata);
        sel = inst;
        #1;
        check("issue.ready", 64'(m_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back(exp_rdata);
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // One bus beat: fields must be stable for waits cycles, ack on the last.
    task automatic beat(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] be, input logic [63:0] data,
                        input int waits, input logic [63:0] rdata);
        for (int w = 0; w <= waits; w++) begin
            check({tag, ".rd_en"}, 64'(m_rd), 64'(!wr));
            check({tag, ".wr_en"}, 64'(m_wr), 64'(wr));
            check({tag, ".addr"},  m_addr, addr);
            check({tag, ".be"},    64'(m_be), be);
            check({tag, ".data"},  m_data, data);
            if (w == waits) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            @(negedge clk);
        end
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic no_strobe(input string tag);
        check({tag, ".rd_off"}, 64'(m_rd), 64'd0);
        check({tag, ".wr_off"}, 64'(m_wr), 64'd0);
        @(negedge clk);
    endtask

    task automatic resp(input string tag, input logic fault, input logic [1:0] cause);
        logic [63:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
        check({tag, ".rsp_valid"}, 64'(m_rsp_valid), 64'd1);
        check({tag, ".fault"},     64'(m_fault), 64'(fault));
        check({tag, ".cause"},     64'(m_cause), 64'(cause));
        check({tag, ".rdata"},     m_rdata, exp);
        @(negedge clk);
        check({tag, ".rsp_pulse"}, 64'(m_rsp_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(m_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    // ---------------- directed vectors ----------------
    initial begin
        rst = 1'b1; sel = 0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset.ready", 64'(m_ready), 64'd1);
            check("reset.state", 64'(m_state), 64'(ST_IDLE));
            check("reset.rd_en", 64'(m_rd), 64'd0);
            check("reset.wr_en", 64'(m_wr), 64'd0);
            check("reset.be", 64'(m_be), 64'd0);
            check("reset.rsp_valid", 64'(m_rsp_valid), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // A: aligned load word, zero wait -> response in cycle 2
        issue(0, 1'b0, 3'b010, 64'h100, 64'h0, 64'h8000_00F0);
        beat("lw", 1'b0, 64'h100, 64'hF, 64'h0, 0, 64'h8000_00F0);
        resp("lw", 1'b0, CAUSE_NONE);

        // A: store byte at offset 3; upper wdata bytes shift out
        issue(0, 1'b1, 3'b000, 64'h203, 64'h1234_56AB, 64'h0);
        beat("sb", 1'b1, 64'h200, 64'h8, 64'hAB00_0000, 1, 64'h0);
        resp("sb", 1'b0, CAUSE_NONE);

        // A: split signed halfword at 0x203 -> response in cycle 4
        issue(0, 1'b0, 3'b001, 64'h203, 64'h0, 64'hFFFF_8811);
        beat("lh_split.b1", 1'b0, 64'h200, 64'h8, 64'h0, 0, 64'h1122_3344);
        no_strobe("lh_split.gap");
        beat("lh_split.b2", 1'b0, 64'h204, 64'h1, 64'h0, 0, 64'h5566_7788);
        resp("lh_split", 1'b0, CAUSE_NONE);

        // A: same access unsigned, with wait states on beat 2
        issue(0, 1'b0, 3'b101, 64'h203, 64'h0, 64'h0000_8811);
        beat("lhu_split.b1", 1'b0, 64'h200, 64'h8, 64'h0, 0, 64'h1122_3344);
        no_strobe("lhu_split.gap");
        beat("lhu_split.b2", 1'b0, 64'h204, 64'h1, 64'h0, 2, 64'h5566_7788);
        resp("lhu_split", 1'b0, CAUSE_NONE);

        // A: split halfword store
        issue(0, 1'b1, 3'b001, 64'h203, 64'h0000_BEEF, 64'h0);
        beat("sh_split.b1", 1'b1, 64'h200, 64'h8, 64'hEF00_0000, 0, 64'h0);
        no_strobe("sh_split.gap");
        beat("sh_split.b2", 1'b1, 64'h204, 64'h1, 64'h0000_00BE, 0, 64'h0);
        resp("sh_split", 1'b0, CAUSE_NONE);

        // A: non-crossing misaligned halfword and a signed byte
        issue(0, 1'b0, 3'b001, 64'h201, 64'h0, 64'hFFFF_A5B6);
        beat("lh_off1", 1'b0, 64'h200, 64'h6, 64'h0, 0, 64'h00A5_B600);
        resp("lh_off1", 1'b0, CAUSE_NONE);
        issue(0, 1'b0, 3'b000, 64'h202, 64'h0, 64'hFFFF_FFF0);
        beat("lb_off2", 1'b0, 64'h200, 64'h4, 64'h0, 0, 64'h12F0_3456);
        resp("lb_off2", 1'b0, CAUSE_NONE);

        // A: illegal sizes fault immediately with no bus activity
        issue(0, 1'b0, 3'b011, 64'h100, 64'h0, 64'h0);
        check("ld32.no_rd", 64'(m_rd), 64'd0);
        resp("ld32", 1'b1, CAUSE_ILLEGAL);
        issue(0, 1'b1, 3'b110, 64'h100, 64'h1, 64'h0);
        check("st_uns.no_wr", 64'(m_wr), 64'd0);
        resp("st_uns", 1'b1, CAUSE_ILLEGAL);

        // A: watchdog, strobes held cycles 1..4, fault in cycle 5, late ack ignored
        issue(0, 1'b0, 3'b010, 64'h300, 64'h0, 64'h0);
        for (int w = 0; w < 4; w++) begin
            check("to.rd_held", 64'(m_rd), 64'd1);
            check("to.addr_held", m_addr, 64'h300);
            @(negedge clk);
        end
        check("to.rd_drop", 64'(m_rd), 64'd0);
        bus_ack = 1'b1;
        resp("to", 1'b1, CAUSE_TIMEOUT);
        check("to.idle", 64'(m_state), 64'(ST_IDLE));
        @(negedge clk);
        check("to.late_ack_rd", 64'(m_rd), 64'd0);
        check("to.late_ack_rsp", 64'(m_rsp_valid), 64'd0);
        check("to.late_ack_ready", 64'(m_ready), 64'd1);
        bus_ack = 1'b0;
        issue(0, 1'b0, 3'b010, 64'h104, 64'h0, 64'h0BAD_F00D);
        beat("after_to", 1'b0, 64'h104, 64'hF, 64'h0, 0, 64'h0BAD_F00D);
        resp("after_to", 1'b0, CAUSE_NONE);

        // B: crossing accesses fault with cause 1, legal store still works
        issue(1, 1'b0, 3'b001, 64'h203, 64'h0, 64'h0);
        check("nosplit_lh.no_rd", 64'(m_rd), 64'd0);
        resp("nosplit_lh", 1'b1, CAUSE_MISALIGN);
        issue(1, 1'b0, 3'b010, 64'h202, 64'h0, 64'h0);
        check("nosplit_lw.no_rd", 64'(m_rd), 64'd0);
        resp("nosplit_lw", 1'b1, CAUSE_MISALIGN);
        issue(1, 1'b1, 3'b010, 64'h40, 64'hCAFE_BABE, 64'h0);
        beat("nosplit_sw", 1'b1, 64'h40, 64'hF, 64'hCAFE_BABE, 0, 64'h0);
        resp("nosplit_sw", 1'b0, CAUSE_NONE);

        // C: doubleword with ack in cycle 3 -> response in cycle 4
        issue(2, 1'b0, 3'b011, 64'h1008, 64'h0, 64'h8123_4567_89AB_CDEF);
        beat("ld64", 1'b0, 64'h1008, 64'hFF, 64'h0, 2, 64'h8123_4567_89AB_CDEF);
        resp("ld64", 1'b0, CAUSE_NONE);
        issue(2, 1'b0, 3'b010, 64'h100C, 64'h0, 64'hFFFF_FFFF_8000_0001);
        beat("lw64_hi", 1'b0, 64'h1008, 64'hF0, 64'h0, 0, 64'h8000_0001_DEAD_BEEF);
        resp("lw64_hi", 1'b0, CAUSE_NONE);
        issue(2, 1'b0, 3'b110, 64'h100E, 64'h0, 64'h0000_0000_CCDD_AABB);
        beat("lwu64_split.b1", 1'b0, 64'h1008, 64'hC0, 64'h0, 0, 64'hAABB_0000_0000_0000);
        no_strobe("lwu64_split.gap");
        beat("lwu64_split.b2", 1'b0, 64'h1010, 64'h03, 64'h0, 0, 64'h0000_0000_0000_CCDD);
        resp("lwu64_split", 1'b0, CAUSE_NONE);

        // C: reset while waiting in beat 2 aborts with no response
        issue(2, 1'b0, 3'b110, 64'h100E, 64'h0, 64'h0);
        beat("rst.b1", 1'b0, 64'h1008, 64'hC0, 64'h0, 0, 64'hAABB_0000_0000_0000);
        no_strobe("rst.gap");
        check("rst.b2_live", 64'(m_rd), 64'd1);
        check("rst.b2_be", 64'(m_be), 64'h03);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst.rd_drop", 64'(m_rd), 64'd0);
        check("rst.no_rsp", 64'(m_rsp_valid), 64'd0);
        check("rst.ready", 64'(m_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst.no_rsp_after", 64'(m_rsp_valid), 64'd0);
        check("rst.state_idle", 64'(m_state), 64'(ST_IDLE));
        if (exp_q.size() != 0) void'(exp_q.pop_front());

        // ---------------- report ----------------
        check("scoreboard.drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised multicycle memory-access engine that sits between the core datapath and the memory bus.
- Generalises the core's fixed 32-bit, funct3-indexed byte-enable path in four ways:
  - configurable bus width (32/64);
  - lane-shifted write data and byte enables;
  - sign/zero-extended load data;
  - misaligned handling (split into two bus beats, or fault) and an ack-timeout watchdog.
- The core issues one request at a time and receives one response pulse.

Parameters:
- XLEN, 32, datapath and bus width in bits; legal values are 32 or 64. B = XLEN/8 byte lanes.
- TIMEOUT_CYCLES, 256, cycles to wait for ack_i per beat; 0 disables the watchdog.
- SPLIT_MISALIGNED, 1, 1 = accesses crossing a bus word use two beats; 0 = they fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request strobe
- req_ready_o  out  1  high only in IDLE; a request is accepted when valid & ready
- req_write_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V funct3: [1:0] size (0 B, 1 H, 2 W, 3 D); [2] unsigned load
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, right-justified
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and faults
- rsp_fault_o  out  1  access faulted
- rsp_cause_o  out  2  1 misaligned, 2 timeout, 3 illegal size
- rd_en_o  out  1  bus read
- wr_en_o  out  1  bus write
- byte_enable_o  out  B  lane enables
- addr_o  out  XLEN  bus address, always B-aligned
- data_o  out  XLEN  lane-shifted store data
- data_i  in  XLEN  bus read data, valid when ack_i is high
- ack_i  in  1  bus completion

Behaviour:
- Reset:
  - state = IDLE.
  - req_ready_o = 1.
  - All other outputs are 0.
  - Beat and timeout counters are cleared.
- Reset mid-operation: the access is aborted, bus strobes drop on the next edge, and no response is issued.
- States: IDLE, BEAT1, BEAT2, RESP.
- Decode at acceptance; all request fields are registered:
  - sz = 1 << funct3[1:0].
  - off = addr mod B.
  - cross = (off + sz > B).
  - Illegal size: size D when XLEN = 32, or a store with funct3[2] = 1.
- IDLE, on accept:
  - Illegal size -> RESP with cause 3.
  - Else cross and SPLIT_MISALIGNED = 0 -> RESP with cause 1.
  - Else -> BEAT1.
  - No bus activity on either fault path.
- Non-crossing misaligned accesses (e.g. a halfword at offset 1) are legal single beats.
- BEAT1 drive:
  - addr_o = addr & ~(B-1).
  - byte_enable_o = ((1<<sz)-1) << off, truncated to B bits.
  - data_o = wdata << 8*off.
- BEAT2 drive:
  - addr_o = aligned address + B.
  - byte_enable_o = the overflow bits of the BEAT1 mask.
  - data_o = wdata >> 8*(B-off).
- Bus handshake:
  - rd_en_o/wr_en_o and all bus fields are registered and held stable until the cycle ack_i is sampled high.
  - On the ack cycle, strobes drop on the next edge.
  - On ack: BEAT1 goes to BEAT2 if cross, else to RESP; BEAT2 goes to RESP.
- Load assembly:
  - Enabled lanes of data_i from each beat are captured into a 2B-byte staging register.
  - The sz bytes are extracted from offset off and sign-extended (funct3[2] = 0) or zero-extended (funct3[2] = 1).
- Watchdog:
  - Counter is cleared on entry to each beat and increments every cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: strobes drop, then RESP with cause 2.
  - A late ack arriving in RESP/IDLE is ignored.
  - A split store timing out in BEAT2 leaves beat 1 committed; this is architecturally visible and accepted.
- RESP:
  - rsp_valid_o is high for exactly one cycle, then IDLE.
  - rsp_rdata_o and rsp_fault_o are valid in that cycle.
- Latency:
  - Request accepted at edge 0; strobes visible in cycle 1.
  - Ack in cycle k -> rsp_valid_o in cycle k+1.
  - Aligned zero-wait access: response in cycle 2.
  - Split zero-wait access: response in cycle 4.
  - Immediate fault: response in cycle 1.
- ack_i asserted outside BEAT1/BEAT2 is ignored.
- req_valid_i is ignored when req_ready_o = 0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - cause constants (CAUSE_MISALIGN = 1, CAUSE_TIMEOUT = 2, CAUSE_ILLEGAL = 3);
  - the state encoding.
- Sub-module lsu_align (combinational):
  - beat masks and shifted write data from (off, sz, wdata);
  - load extraction and extension from the staging register.
- The FSM, registers and watchdog stay in load_store_unit.

Test Plan:
- XLEN = 32, load word at 0x100, ack in cycle 1, data_i = 0x8000_00F0:
  - addr_o = 0x100, byte_enable_o = 1111;
  - rsp_rdata_o = 0x8000_00F0, valid in cycle 2.
- XLEN = 32, store byte 0xAB at 0x203:
  - addr_o = 0x200, byte_enable_o = 1000, data_o = 0xAB00_0000.
- XLEN = 32, load halfword at 0x203, SPLIT_MISALIGNED = 1, data_i = 0x1122_3344 then 0x5566_7788:
  - beats at 0x200 (be 1000) and 0x204 (be 0001);
  - rsp_rdata_o = 0x0000_8811 sign-extended, i.e. 0xFFFF_8811.
- Same access with SPLIT_MISALIGNED = 0:
  - no strobes;
  - rsp_fault_o = 1, cause 1, valid in cycle 1.
- TIMEOUT_CYCLES = 4, ack never asserted:
  - strobes held for 4 cycles, then dropped;
  - fault with cause 2; a later ack is ignored and req_ready_o returns to 1.
- XLEN = 64, load doubleword at 0x...08 with ack delayed 3 cycles:
  - rsp_rdata_o equals data_i in cycle 4;
  - rst asserted during a BEAT2 wait drops strobes next edge with no rsp_valid_o.
